// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

  // Opcode field values handled by the controller
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU operation requests (3-bit core encoding)
  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

endpackage

// File: rtl/ctrl_next_state.sv
// Combinational next-state function of the multi-cycle control FSM.
module ctrl_next_state
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op_q,
  input  logic [5:0] i_instr_op,
  input  logic       i_mem_ready,
  output state_t     o_next
);

  // Next state: opcode dispatch in DECODE uses the live opcode, later states the latched one
  always_comb begin
    o_next = i_state;
    case (i_state)
      S_RST:      o_next = S_FETCH;
      S_FETCH:    o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_instr_op)
          OP_RTYPE:        o_next = S_R_EXEC;
          OP_J:            o_next = S_JUMP;
          OP_BEQ, OP_BNE:  o_next = S_BRANCH;
          OP_ADDI, OP_SLTI: o_next = S_I_EXEC;
          OP_LW, OP_SW:    o_next = S_MEM_ADDR;
          default:         o_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: o_next = (i_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   o_next = i_mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   o_next = S_FETCH;
      S_MEM_WR:   o_next = i_mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   o_next = S_R_WB;
      S_R_WB:     o_next = S_FETCH;
      S_I_EXEC:   o_next = S_I_WB;
      S_I_WB:     o_next = S_FETCH;
      S_BRANCH:   o_next = S_FETCH;
      S_JUMP:     o_next = S_FETCH;
      S_TRAP:     o_next = S_TRAP;
      default:    o_next = S_RST;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath (FETCH write-enables gated by mem_ready).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                ir_write_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                alu_src_a_o,
  output logic                branch_ne_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          pc_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o,
  output logic [STATE_W-1:0]  state_o
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op_q;
  logic [2:0] w_alu_op;

  ctrl_next_state u_next (
    .i_state     (r_state),
    .i_op_q      (r_op_q),
    .i_instr_op  (instr_op_i),
    .i_mem_ready (mem_ready_i),
    .o_next      (w_next)
  );

  // State register; reset aborts any instruction or pending memory access immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_RST;
    else        r_state <= w_next;
  end

  // Opcode latch: captured only in DECODE so later opcode changes are ignored
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   r_op_q <= '0;
    else if (r_state == S_DECODE) r_op_q <= instr_op_i;
  end

  // Output decode: everything defaults low, each state raises only its own controls
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    branch_ne_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    pc_src_o        = PCSRC_ALU;
    w_alu_op        = ALU_RTYPE;
    illegal_o       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        w_alu_op    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        w_alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        w_alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_RT;
        w_alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        w_alu_op    = (r_op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = SRCB_RT;
        w_alu_op        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PCSRC_ALUOUT;
        branch_ne_o     = (r_op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PCSRC_JUMP;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op_o = ALU_OP_W'(w_alu_op);
  assign state_o  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level sequence model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] instr_op_i = '0;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, reg_dst_o;
  logic       alu_src_a_o, branch_ne_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(.ALU_OP_W(3), .STATE_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .ir_write_o(ir_write_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .alu_src_a_o(alu_src_a_o), .branch_ne_o(branch_ne_o), .alu_src_b_o(alu_src_b_o),
    .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, got no $finish expected one");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
  //  reg_write, reg_dst, alu_src_a, branch_ne, illegal, alu_src_b, pc_src, alu_op}
  function automatic logic [31:0] observed();
    return {13'd0, pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
            mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o, branch_ne_o, illegal_o,
            alu_src_b_o, pc_src_o, alu_op_o};
  endfunction

  // Control word the datapath expects in each step, from the state action table
  function automatic logic [31:0] expected(input state_t s, input logic [5:0] op, input bit rdy);
    logic pcw = 0, pcc = 0, irw = 0, iod = 0, mr = 0, mw = 0, m2r = 0, rw = 0, rd = 0;
    logic asa = 0, bne = 0, ill = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ao = 3'b000;
    case (s)
      S_FETCH:    begin mr = 1; sb = 2'b01; ao = 3'b010; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sb = 2'b11; ao = 3'b010; end
      S_MEM_ADDR: begin asa = 1; sb = 2'b10; ao = 3'b010; end
      S_MEM_RD:   begin mr = 1; iod = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mw = 1; iod = 1; end
      S_R_EXEC:   begin asa = 1; end
      S_R_WB:     begin rw = 1; rd = 1; end
      S_I_EXEC:   begin asa = 1; sb = 2'b10; ao = (op == 6'd10) ? 3'b011 : 3'b010; end
      S_I_WB:     begin rw = 1; end
      S_BRANCH:   begin asa = 1; ao = 3'b001; pcc = 1; ps = 2'b01; bne = (op == 6'd5); end
      S_JUMP:     begin pcw = 1; ps = 2'b10; end
      S_TRAP:     begin ill = 1; end
      default: ;
    endcase
    return {13'd0, pcw, pcc, irw, iod, mr, mw, m2r, rw, rd, asa, bne, ill, sb, ps, ao};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd35, 6'd43};
  endfunction

  // Asynchronous reset mid-cycle, checked before any clock edge, released on a falling edge
  task automatic do_reset(input string tag);
    #2 rst_i = 1'b0;
    #1;
    check({tag, ":rst_state"}, 32'(state_o), 32'(S_RST));
    check({tag, ":rst_outs"}, observed(), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Run one instruction: build the expected per-cycle step list, then drive and compare
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int abort_at);
    state_t q[$];
    bit     r[$];
    string  tag;
    repeat (fstall) begin q.push_back(S_FETCH); r.push_back(1'b0); end
    q.push_back(S_FETCH);  r.push_back(1'b1);
    q.push_back(S_DECODE); r.push_back(1'($urandom));
    case (op)
      6'd0:        begin q.push_back(S_R_EXEC); q.push_back(S_R_WB); end
      6'd8, 6'd10: begin q.push_back(S_I_EXEC); q.push_back(S_I_WB); end
      6'd4, 6'd5:  q.push_back(S_BRANCH);
      6'd2:        q.push_back(S_JUMP);
      6'd35: begin
        q.push_back(S_MEM_ADDR); r.push_back(1'($urandom));
        repeat (mstall) begin q.push_back(S_MEM_RD); r.push_back(1'b0); end
        q.push_back(S_MEM_RD); r.push_back(1'b1);
        q.push_back(S_MEM_WB);
      end
      6'd43: begin
        q.push_back(S_MEM_ADDR); r.push_back(1'($urandom));
        repeat (mstall) begin q.push_back(S_MEM_WR); r.push_back(1'b0); end
        q.push_back(S_MEM_WR); r.push_back(1'b1);
      end
      default: repeat (8) q.push_back(S_TRAP);
    endcase
    while (r.size() < q.size()) r.push_back(1'($urandom));

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk_i);
      #1;
      instr_op_i  = (q[i] == S_DECODE) ? op : 6'($urandom);
      mem_ready_i = r[i];
      @(negedge clk_i);
      tag = $sformatf("op%0d.c%0d", op, i);
      check({tag, ":state"}, 32'(state_o), 32'(q[i]));
      check({tag, ":outs"}, observed(), expected(q[i], op, r[i]));
      if (i == abort_at) begin
        do_reset({tag, ":abort"});
        return;
      end
    end
    if (!is_legal(op)) do_reset($sformatf("op%0d.trap", op));
  endtask

  initial begin
    logic [5:0] legal_ops [8] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd10, 6'd35, 6'd43};
    logic [5:0] bad;

    // Held in reset: RST, everything low
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset:state", 32'(state_o), 32'(S_RST));
    check("reset:outs", observed(), 32'd0);
    rst_i = 1'b1;

    // Directed: R-type, lw, sw with memory wait, branches, jump, slti
    run_instr(6'd0, 0, 0, -1);
    run_instr(6'd35, 0, 0, -1);
    run_instr(6'd43, 0, 3, -1);
    run_instr(6'd5, 0, 0, -1);
    run_instr(6'd4, 0, 0, -1);
    run_instr(6'd2, 0, 0, -1);
    run_instr(6'd10, 0, 0, -1);

    // Random legal instructions with random FETCH and memory stalls
    for (int k = 0; k < 60; k++)
      run_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), -1);

    // Reset during a stalled load; then refetch
    run_instr(6'd35, 1, 3, 5);
    run_instr(6'd0, 0, 0, -1);

    // Illegal opcodes trap and stay trapped until reset
    run_instr(6'd63, 0, 0, -1);
    do begin bad = 6'($urandom); end while (is_legal(bad));
    run_instr(bad, $urandom_range(0, 2), 0, -1);
    run_instr(6'd8, 0, 0, -1);
    run_instr(6'd43, 2, 1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath. It is the successor to the single-cycle opcode decoder and sequences each instruction over 3–5 states. It also supports lw/sw/j/bne, a memory ready handshake and an illegal-opcode trap. It sits between the instruction register's opcode field and every datapath mux and write-enable.

## Interface
- `ALU_OP_W`, default 3: ALU_op width. Must be ≥3; the upper bits beyond 3 are driven 0.
- `STATE_W`, default 4: width of the state encoding exported on `state_o`.
- `clk_i`, input, 1: single clock. All state updates occur on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-low.
- `instr_op_i`, input, 6: opcode field of the instruction register. Sampled in DECODE.
- `mem_ready_i`, input, 1: memory completes the current access this cycle.
- `pc_write_o`, `pc_write_cond_o`, `ir_write_o`, `i_or_d_o`: output, 1 each.
- `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `reg_write_o`, `reg_dst_o`: output, 1 each.
- `alu_src_a_o`, `branch_ne_o`: output, 1 each.
- `alu_src_b_o`, output, 2: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `pc_src_o`, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op_o`, output, `ALU_OP_W`: 000 = R-type (funct decides), 001 = subtract, 010 = add, 011 = set-less-than.
- `illegal_o`, output, 1: sticky trap flag.
- `state_o`, output, `STATE_W`: current state, for debug.

## Operation
- States: RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- All outputs default to 0; each state asserts only the signals listed below.
- **RST:** all outputs 0. Moves to FETCH on the first edge after `rst_i` deasserts.
- **FETCH:**
  - `mem_read_o`=1, `i_or_d_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=01, `alu_op_o`=010.
  - `ir_write_o` and `pc_write_o` = `mem_ready_i`; this qualification is the only Mealy term.
  - Stays in FETCH while `mem_ready_i`=0; otherwise goes to DECODE.
- **DECODE:**
  - `alu_src_b_o`=11, `alu_op_o`=010 (computes the branch target).
  - Registers `instr_op_i` into an internal opcode register, `op_q`. Later states use only `op_q`.
  - Next state by opcode: 0 → R_EXEC; 2 → JUMP; 4 or 5 → BRANCH; 8 or 10 → I_EXEC; 35 or 43 → MEM_ADDR; any other opcode → TRAP.
- **MEM_ADDR:** `alu_src_a_o`=1, `alu_src_b_o`=10, `alu_op_o`=010. Goes to MEM_RD if `op_q`=35, otherwise MEM_WR.
- **MEM_RD:** `mem_read_o`=1, `i_or_d_o`=1. Waits while `mem_ready_i`=0, then goes to MEM_WB.
- **MEM_WB:** `reg_write_o`=1, `mem_to_reg_o`=1, `reg_dst_o`=0. Then FETCH.
- **MEM_WR:** `mem_write_o`=1, `i_or_d_o`=1. Waits while `mem_ready_i`=0, then goes to FETCH.
- **R_EXEC:** `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=000. Then R_WB.
- **R_WB:** `reg_write_o`=1, `reg_dst_o`=1. Then FETCH.
- **I_EXEC:** `alu_src_a_o`=1, `alu_src_b_o`=10. `alu_op_o`=010 for opcode 8 (addi), 011 for opcode 10 (slti). Then I_WB.
- **I_WB:** `reg_write_o`=1, `reg_dst_o`=0, `mem_to_reg_o`=0. Then FETCH.
- **BRANCH:**
  - `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=001.
  - `pc_write_cond_o`=1, `pc_src_o`=01.
  - `branch_ne_o` = (`op_q`==5).
  - Then FETCH.
- **JUMP:** `pc_write_o`=1, `pc_src_o`=10. Then FETCH.
- **TRAP:** `illegal_o`=1, all other outputs 0. Absorbing: only reset leaves it.

## Timing
- State register updates on the rising edge of `clk_i`.
- Asserting `rst_i` forces RST immediately, without waiting for a clock edge, including mid-instruction. A pending memory access is abandoned.
- Instruction latency with zero-wait memory (`mem_ready_i`=1 throughout):
  - R-type, addi, slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
- Each cycle with `mem_ready_i`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Outputs hold stable during the wait.
- During a stalled FETCH, `pc_write_o` and `ir_write_o` stay 0, so the PC never advances twice.
- `instr_op_i` changing in any state other than DECODE has no effect.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants: `OP_RTYPE`=0, `OP_J`=2, `OP_BEQ`=4, `OP_BNE`=5, `OP_ADDI`=8, `OP_SLTI`=10, `OP_LW`=35, `OP_SW`=43;
  - the ALU_op encodings;
  - the ALUSrcB and PCSrc encodings;
  - the state enum.
- One sub-module, `ctrl_next_state`: a combinational next-state function of (state, `op_q`, `instr_op_i`, `mem_ready_i`).
- The state register, the `op_q` register and the output decode live in the top module.

## Test plan
- **Reset:** hold `rst_i`=0, release, keep `mem_ready_i`=1.
  - During reset: `state_o`=RST and all outputs 0.
  - One cycle after release: FETCH, with `pc_write_o`=1 and `alu_op_o`=010.
- **R-type and lw latency:** opcode 0 then opcode 35, `mem_ready_i`=1.
  - R-type: states FETCH → DECODE → R_EXEC → R_WB; `reg_dst_o`=1 in R_WB.
  - lw: 5 cycles; `mem_to_reg_o`=1 and `reg_write_o`=1 in MEM_WB.
- **Memory wait:** opcode 43, `mem_ready_i` low for 3 cycles in MEM_WR. `mem_write_o` stays high for 4 cycles; the instruction takes 7 cycles in total.
- **Branches and jump:**
  - opcode 5: `pc_write_cond_o`=1 with `branch_ne_o`=1.
  - opcode 4: same, with `branch_ne_o`=0.
  - opcode 2: `pc_src_o`=10 and `pc_write_o`=1; 3 cycles each.
- **slti and illegal opcode:**
  - opcode 10: `alu_op_o`=011 in I_EXEC.
  - opcode 63: reaches TRAP and `illegal_o` stays 1 indefinitely.
  - Asserting `rst_i` clears `illegal_o` asynchronously.
- **Mid-stall reset:** `rst_i` asserted during a stalled MEM_RD. Outputs go to 0 immediately and the FSM refetches after release.
